// File: rtl/regbank_writer.sv
// Write side of the 32-entry register bank: an in-order write queue feeding a
// one-hot decoded commit into 32 registers, exported flat for the read mux.
module regbank_writer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [4:0]          wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                commit_en,
  input  logic                flush,
  output logic [32*WIDTH-1:0] regs_flat,
  output logic [31:0]         wen_last,
  output logic [CNTW-1:0]     count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  typedef enum logic [1:0] {
    Q_EMPTY,
    Q_PARTIAL,
    Q_FULL
  } qstate_t;

  qstate_t qstate;

  logic [4:0]       addr_mem_q [DEPTH];
  logic [4:0]       addr_mem_d [DEPTH];
  logic [WIDTH-1:0] data_mem_q [DEPTH];
  logic [WIDTH-1:0] data_mem_d [DEPTH];
  logic [PTRW-1:0]  head_q, head_d;
  logic [PTRW-1:0]  tail_q, tail_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] regs_q [32];
  logic [WIDTH-1:0] regs_d [32];
  logic [31:0]      wen_last_q, wen_last_d;
  logic [31:0]      wen;
  logic             accept;
  logic             do_commit;
  logic [4:0]       head_addr;
  logic [WIDTH-1:0] head_data;

  always_comb begin
    qstate = Q_PARTIAL;
    if (count_q == '0) begin
      qstate = Q_EMPTY;
    end else if (count_q == FULL_CNT) begin
      qstate = Q_FULL;
    end
  end

  // No pass-through when full: a same-cycle commit does not free a slot early.
  assign wr_ready  = rst_n && (qstate != Q_FULL) && !flush;
  assign accept    = wr_valid && wr_ready;
  assign do_commit = (qstate != Q_EMPTY) && commit_en && !flush;
  assign head_addr = addr_mem_q[head_q];
  assign head_data = data_mem_q[head_q];

  always_comb begin
    wen = '0;
    if (do_commit) begin
      wen[head_addr] = 1'b1;
    end
    wen[0] = 1'b0;
  end

  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (accept) begin
        addr_mem_d[tail_q] = wr_addr;
        data_mem_d[tail_q] = wr_data;
        tail_d             = tail_q + PTRW'(1);
      end
      if (do_commit) begin
        head_d = head_q + PTRW'(1);
      end
      case ({accept, do_commit})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      regs_d[r] = wen[r] ? head_data : regs_q[r];
    end
    regs_d[0]  = '0;
    wen_last_d = wen;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
      for (int r = 0; r < 32; r++) begin
        regs_q[r] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      wen_last_q <= '0;
    end else begin
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
      regs_q     <= regs_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wen_last_q <= wen_last_d;
    end
  end

  for (genvar g = 0; g < 32; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
  end

  assign wen_last = wen_last_q;
  assign count    = count_q;

endmodule

// File: doc/regbank_writer.md
# regbank_writer

Write side of the 32-entry register bank: the counterpart to the 32:1 read multiplexer. Accepts write requests over a valid/ready handshake, buffers them in a small in-order queue, decodes each address into a one-hot write enable and commits one write per cycle into 32 storage registers. The full bank is exported flattened so the existing 32-to-1 read mux can select from it; register 0 always reads zero.

## Interface
- WIDTH, 32, data width of each register
- DEPTH, 2, write-queue entries (power of two, at least 2)
- CNTW, $clog2(DEPTH)+1, width of the occupancy count
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous and active-low
- wr_valid  in  1  write request present
- wr_ready  out  1  queue can accept a request this cycle
- wr_addr  in  5  destination register index
- wr_data  in  WIDTH  data to write
- commit_en  in  1  allows the queue head to commit this cycle (low = stall)
- flush  in  1  discard all queued, uncommitted writes
- regs_flat  out  32*WIDTH  register r at bits [r*WIDTH +: WIDTH]
- wen_last  out  32  one-hot enable of the commit performed at the last edge
- count  out  CNTW  queue occupancy

## Operation
- Accept: when wr_valid && wr_ready at an edge, {wr_addr, wr_data} is appended at the queue tail.
- wr_ready = rst_n && (count < DEPTH) && !flush. There is no pass-through when full, even if a commit happens in the same cycle.
- Commit: when count > 0 && commit_en && !flush at an edge:
  - the head entry is dequeued;
  - the 5-to-32 decoder drives a one-hot enable for head.addr;
  - that register loads head.data.
- Address 0: the decoder output is forced to all-zero. The entry is still dequeued, regs_flat[WIDTH-1:0] stays 0, and wen_last goes to 0.
- Ordering is strict FIFO. Two queued writes to the same address commit in acceptance order, so the later one wins.
- Simultaneous accept and commit: count is unchanged and the tail and head pointers both advance. Pointers wrap modulo DEPTH.
- Flush has priority over everything else at its edge:
  - count becomes 0 and both pointers are reset;
  - no commit and no accept take place;
  - register contents are untouched;
  - wen_last becomes 0.
- Queue states, derived from count: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
  - EMPTY to PARTIAL on accept without commit.
  - PARTIAL to FULL on accept without commit when count = DEPTH-1.
  - FULL to PARTIAL on commit (no accept is possible while FULL).
  - Any state to EMPTY on flush.
- wen_last is registered. It holds the one-hot enable of the commit at the last edge, and is 0 if no commit occurred or the commit targeted r0.

## Timing
- Reset, applied at an edge with rst_n = 0:
  - all 32 registers become 0, count becomes 0, pointers become 0, wen_last becomes 0;
  - wr_ready is 0 while rst_n is low.
- Reset mid-operation discards queued writes. It takes priority over flush, accept and commit.
- Latency: a request accepted at edge N with commit_en high appears in regs_flat after edge N+1, with wen_last reflecting it over the same cycle. A non-empty queue delays this by one cycle per entry ahead of it.
- Throughput: one accept and one commit per cycle in steady state.
- count, regs_flat and wen_last change only at clock edges. wr_ready is combinational from count, flush and rst_n.

## Test plan
- Reset, then write 0xDEADBEEF to r5 with commit_en = 1:
  - after the next edge count = 1;
  - one edge later regs_flat[5*32 +: 32] = 0xDEADBEEF, wen_last = 0x00000020, count = 0.
- Write 0x12345678 to r0:
  - entry is dequeued, regs_flat[31:0] stays 0, wen_last = 0, count returns to 0.
- Fill and stall with commit_en = 0:
  - accept writes to r1 and r2, giving count = 2 and wr_ready = 0;
  - a third wr_valid is not accepted;
  - raise commit_en: r1 commits first, then r2; wr_ready = 1 once count = 1.
- Same-address ordering: queue r7 = 0x1, then r7 = 0x2 while stalled, then release:
  - r7 = 0x2 at the end;
  - wen_last = 0x00000080 on both commit cycles.
- Flush with count = 2 (writes to r3 and r4 pending) and commit_en = 1 in the flush cycle:
  - count = 0, r3 and r4 keep their prior values, wen_last = 0.
- Reset asserted with count = 1 and nonzero registers:
  - all regs_flat = 0, count = 0, wr_ready = 0 during reset and 1 on the first cycle after rst_n rises.
